raster_frame_sequencer: RTL

Per-frame controller for the rasterizer's frame-buffer write port, sitting between the line generator and the frame buffer. On each frame start it first clears the whole frame to the background colour with an internal sweep. It then hands the write port to the line generator's pixel stream, back-pressuring the generator whenever the port is busy. Once end-of-objects has been seen and the line FIFO and generator are idle, it signals frame completion.

---
 rtl/raster_frame_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/raster_frame_sequencer.sv
// Frame-buffer write-port sequencer: clears each frame to the background colour,
// then forwards line-generator pixels until the frame's objects have drained.
module raster_frame_sequencer #(
   parameter int H_PIXELS = 640,
   parameter int V_PIXELS = 480
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic       end_of_objects,
   input  logic [2:0] bk_color,
   input  logic       fifo_empty,
   input  logic       lg_busy,
   input  logic       lg_px_valid,
   input  logic [9:0] lg_x,
   input  logic [8:0] lg_y,
   input  logic [2:0] lg_color,
   output logic       lg_stall,
   input  logic       frame_ready,
   output logic       frame_rd_en,
   output logic [9:0] frame_x,
   output logic [8:0] frame_y,
   output logic [2:0] px_color,
   output logic       raster_done,
   output logic       clear_busy,
   output logic       frame_overrun
);

   localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
   localparam logic [8:0] Y_LAST = 9'(V_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

   state_t     state_q, state_d;
   logic [9:0] x_cnt_q, x_cnt_d;
   logic [8:0] y_cnt_q, y_cnt_d;
   logic [2:0] bk_q, bk_d;
   logic       eoo_seen_q, eoo_seen_d;
   logic       wr_en_q, wr_en_d;
   logic [9:0] wr_x_q, wr_x_d;
   logic [8:0] wr_y_q, wr_y_d;
   logic [2:0] wr_color_q, wr_color_d;
   logic       overrun_q, overrun_d;

   always_comb begin
      state_d    = state_q;
      x_cnt_d    = x_cnt_q;
      y_cnt_d    = y_cnt_q;
      bk_d       = bk_q;
      eoo_seen_d = eoo_seen_q;
      wr_en_d    = 1'b0;
      wr_x_d     = wr_x_q;
      wr_y_d     = wr_y_q;
      wr_color_d = wr_color_q;
      overrun_d  = frame_start && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               bk_d       = bk_color;
               x_cnt_d    = '0;
               y_cnt_d    = '0;
               // an end-of-objects coincident with the accepted start belongs to this frame
               eoo_seen_d = end_of_objects;
               state_d    = CLEAR;
            end
         end
         CLEAR: begin
            eoo_seen_d = eoo_seen_q | end_of_objects;
            if (frame_ready) begin
               wr_en_d    = 1'b1;
               wr_x_d     = x_cnt_q;
               wr_y_d     = y_cnt_q;
               wr_color_d = bk_q;
               if (x_cnt_q == X_LAST) begin
                  x_cnt_d = '0;
                  if (y_cnt_q == Y_LAST) begin
                     y_cnt_d = '0;
                     state_d = DRAW;
                  end else begin
                     y_cnt_d = y_cnt_q + 9'd1;
                  end
               end else begin
                  x_cnt_d = x_cnt_q + 10'd1;
               end
            end
         end
         DRAW: begin
            eoo_seen_d = eoo_seen_q | end_of_objects;
            if (lg_px_valid && frame_ready) begin
               wr_en_d    = 1'b1;
               wr_x_d     = lg_x;
               wr_y_d     = lg_y;
               wr_color_d = lg_color;
            end
            if (eoo_seen_q && fifo_empty && !lg_busy && !lg_px_valid) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         x_cnt_q    <= '0;
         y_cnt_q    <= '0;
         bk_q       <= '0;
         eoo_seen_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_x_q     <= '0;
         wr_y_q     <= '0;
         wr_color_q <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_cnt_q    <= x_cnt_d;
         y_cnt_q    <= y_cnt_d;
         bk_q       <= bk_d;
         eoo_seen_q <= eoo_seen_d;
         wr_en_q    <= wr_en_d;
         wr_x_q     <= wr_x_d;
         wr_y_q     <= wr_y_d;
         wr_color_q <= wr_color_d;
         overrun_q  <= overrun_d;
      end
   end

   // Only DRAW lets the generator advance, and only when the port can take its pixel.
   assign lg_stall      = (state_q == DRAW) ? ~frame_ready : 1'b1;
   assign clear_busy    = (state_q == CLEAR);
   assign raster_done   = (state_q == DONE);
   assign frame_rd_en   = wr_en_q;
   assign frame_x       = wr_x_q;
   assign frame_y       = wr_y_q;
   assign px_color      = wr_color_q;
   assign frame_overrun = overrun_q;

endmodule
